// File: rtl/axi_pkg.sv
// Shared AXI constants and the initiator FSM state encoding.
//
// Contents:
//   AXI_BURST_INCR  - AXI burst type for incrementing bursts (2'b01)
//   AXI_RESP_OKAY   - AXI OKAY response code (2'b00)
//   init_state_e    - axi_pmem_initiator FSM states
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAw   = 3'd1,
    StW    = 3'd2,
    StB    = 3'd3,
    StAr   = 3'd4,
    StR    = 3'd5
  } init_state_e;

endpackage

// File: rtl/axi_init_watchdog.sv
// Watchdog for axi_pmem_initiator: counts consecutive busy cycles that see no AXI handshake.
// Only built when AXI_INIT_TIMEOUT_EN is defined.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   busy_i     - initiator is in a non-idle state
//   hs_i       - some AXI channel handshake happened this cycle
//   timeout_o  - sticky flag, set once the counter reaches 16'hFFFF; cleared only by rst
`ifdef AXI_INIT_TIMEOUT_EN
module axi_init_watchdog (
  input  logic clk,
  input  logic rst,
  input  logic busy_i,
  input  logic hs_i,
  output logic timeout_o
);

  logic [15:0] cnt_q;
  logic        timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      if (!busy_i || hs_i) begin
        cnt_q <= 16'd0;
      end else if (cnt_q != 16'hFFFF) begin
        // Saturate so a long stall cannot wrap back to a small count.
        cnt_q <= cnt_q + 16'd1;
      end
      if (cnt_q == 16'hFFFF) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;

endmodule
`endif

// File: rtl/axi_pmem_initiator.sv
// AXI4 initiator: turns a command + data-stream request into one single-outstanding INCR burst
// on a 32-bit AXI port, counts beats, generates wlast, checks rlast/IDs and reports status.
//
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   cmd_*                          - command handshake (write flag, word address, AXI LEN)
//   wr_*                           - write data stream into the initiator
//   rd_*                           - read data stream out of the initiator
//   done_o / error_o               - one-cycle completion pulse / status valid with done_o
//   timeout_o                      - sticky watchdog flag
//   axi_aw* / axi_w* / axi_b*      - AXI write channels
//   axi_ar* / axi_r*               - AXI read channels
//
// Optional feature: define AXI_INIT_TIMEOUT_EN to build the stall watchdog; otherwise
// timeout_o is tied low.
module axi_pmem_initiator
  import axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [7:0]  cmd_len_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  wr_strb_i,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  output logic [31:0] rd_data_o,
  output logic        rd_last_o,
  output logic        done_o,
  output logic        error_o,
  output logic        timeout_o,
  output logic        axi_awvalid_o,
  output logic [31:0] axi_awaddr_o,
  output logic [3:0]  axi_awid_o,
  output logic [7:0]  axi_awlen_o,
  output logic [1:0]  axi_awburst_o,
  input  logic        axi_awready_i,
  output logic        axi_wvalid_o,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  output logic        axi_wlast_o,
  input  logic        axi_wready_i,
  input  logic        axi_bvalid_i,
  input  logic [1:0]  axi_bresp_i,
  input  logic [3:0]  axi_bid_i,
  output logic        axi_bready_o,
  output logic        axi_arvalid_o,
  output logic [31:0] axi_araddr_o,
  output logic [3:0]  axi_arid_o,
  output logic [7:0]  axi_arlen_o,
  output logic [1:0]  axi_arburst_o,
  input  logic        axi_arready_i,
  input  logic        axi_rvalid_i,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  input  logic [3:0]  axi_rid_i,
  input  logic        axi_rlast_i,
  output logic        axi_rready_o
);

  init_state_e state_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;
  logic        err_acc_q;
  logic        cmd_ready_q;
  logic        awvalid_q;
  logic        arvalid_q;
  logic        bready_q;
  logic        done_q;
  logic        error_q;

  logic last_beat;
  logic w_hs;
  logic r_hs;
  logic b_err;
  logic r_err;
  logic unused_addr_lsb;

  assign last_beat = (beat_q == len_q);
  assign w_hs      = (state_q == StW) && wr_valid_i && axi_wready_i;
  assign r_hs      = (state_q == StR) && axi_rvalid_i && rd_ready_i;
  assign b_err     = (axi_bresp_i != AXI_RESP_OKAY) || (axi_bid_i != AXI_ID);
  // A premature or missing rlast is flagged but the burst still runs to len_q beats.
  assign r_err     = (axi_rresp_i != AXI_RESP_OKAY) || (axi_rid_i != AXI_ID) ||
                     (axi_rlast_i != last_beat);

  // Address is word aligned; the two LSBs of the command are dropped.
  assign unused_addr_lsb = ^cmd_addr_i[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= 32'd0;
      len_q       <= 8'd0;
      beat_q      <= 8'd0;
      err_acc_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            addr_q      <= {cmd_addr_i[31:2], 2'b00};
            len_q       <= cmd_len_i;
            beat_q      <= 8'd0;
            err_acc_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            if (cmd_write_i) begin
              state_q   <= StAw;
              awvalid_q <= 1'b1;
            end else begin
              state_q   <= StAr;
              arvalid_q <= 1'b1;
            end
          end
        end
        StAw: begin
          if (axi_awready_i) begin
            awvalid_q <= 1'b0;
            state_q   <= StW;
          end
        end
        StW: begin
          if (w_hs) begin
            beat_q <= beat_q + 8'd1;
            if (last_beat) begin
              state_q  <= StB;
              bready_q <= 1'b1;
            end
          end
        end
        StB: begin
          if (axi_bvalid_i) begin
            bready_q    <= 1'b0;
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b1;
            error_q     <= err_acc_q | b_err;
          end
        end
        StAr: begin
          if (axi_arready_i) begin
            arvalid_q <= 1'b0;
            state_q   <= StR;
          end
        end
        StR: begin
          if (r_hs) begin
            beat_q <= beat_q + 8'd1;
            if (last_beat) begin
              state_q     <= StIdle;
              cmd_ready_q <= 1'b1;
              done_q      <= 1'b1;
              error_q     <= err_acc_q | r_err;
            end else begin
              err_acc_q <= err_acc_q | r_err;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign done_o        = done_q;
  assign error_o       = error_q;

  assign axi_awvalid_o = awvalid_q;
  assign axi_awaddr_o  = addr_q;
  assign axi_awid_o    = AXI_ID;
  assign axi_awlen_o   = len_q;
  assign axi_awburst_o = AXI_BURST_INCR;

  // Write data passes straight through, but only while in W so early data is held off.
  assign axi_wvalid_o  = (state_q == StW) && wr_valid_i;
  assign wr_ready_o    = (state_q == StW) && axi_wready_i;
  assign axi_wdata_o   = wr_data_i;
  assign axi_wstrb_o   = wr_strb_i;
  assign axi_wlast_o   = (state_q == StW) && last_beat;
  assign axi_bready_o  = bready_q;

  assign axi_arvalid_o = arvalid_q;
  assign axi_araddr_o  = addr_q;
  assign axi_arid_o    = AXI_ID;
  assign axi_arlen_o   = len_q;
  assign axi_arburst_o = AXI_BURST_INCR;

  assign rd_valid_o    = (state_q == StR) && axi_rvalid_i;
  assign axi_rready_o  = (state_q == StR) && rd_ready_i;
  assign rd_data_o     = axi_rdata_i;
  assign rd_last_o     = (state_q == StR) && last_beat;

`ifdef AXI_INIT_TIMEOUT_EN
  logic wd_busy;
  logic wd_hs;

  assign wd_busy = (state_q != StIdle);
  assign wd_hs   = (awvalid_q && axi_awready_i) || (arvalid_q && axi_arready_i) || w_hs ||
                   r_hs || (bready_q && axi_bvalid_i);

  axi_init_watchdog u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .busy_i    (wd_busy),
    .hs_i      (wd_hs),
    .timeout_o (timeout_o)
  );
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_pmem_initiator.sv
// Scoreboard bench for axi_pmem_initiator with a small zero-wait AXI memory responder.
module tb_axi_pmem_initiator;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } addr_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [7:0]  cmd_len_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [31:0] wr_data_i;
  logic [3:0]  wr_strb_i;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic [31:0] rd_data_o;
  logic        rd_last_o;
  logic        done_o;
  logic        error_o;
  logic        timeout_o;
  logic        axi_awvalid_o;
  logic [31:0] axi_awaddr_o;
  logic [3:0]  axi_awid_o;
  logic [7:0]  axi_awlen_o;
  logic [1:0]  axi_awburst_o;
  logic        axi_awready_i;
  logic        axi_wvalid_o;
  logic [31:0] axi_wdata_o;
  logic [3:0]  axi_wstrb_o;
  logic        axi_wlast_o;
  logic        axi_wready_i;
  logic        axi_bvalid_i;
  logic [1:0]  axi_bresp_i;
  logic [3:0]  axi_bid_i;
  logic        axi_bready_o;
  logic        axi_arvalid_o;
  logic [31:0] axi_araddr_o;
  logic [3:0]  axi_arid_o;
  logic [7:0]  axi_arlen_o;
  logic [1:0]  axi_arburst_o;
  logic        axi_arready_i;
  logic        axi_rvalid_i;
  logic [31:0] axi_rdata_i;
  logic [1:0]  axi_rresp_i;
  logic [3:0]  axi_rid_i;
  logic        axi_rlast_i;
  logic        axi_rready_o;

  axi_pmem_initiator dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_write_i   (cmd_write_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_len_i     (cmd_len_i),
    .wr_valid_i    (wr_valid_i),
    .wr_ready_o    (wr_ready_o),
    .wr_data_i     (wr_data_i),
    .wr_strb_i     (wr_strb_i),
    .rd_valid_o    (rd_valid_o),
    .rd_ready_i    (rd_ready_i),
    .rd_data_o     (rd_data_o),
    .rd_last_o     (rd_last_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .timeout_o     (timeout_o),
    .axi_awvalid_o (axi_awvalid_o),
    .axi_awaddr_o  (axi_awaddr_o),
    .axi_awid_o    (axi_awid_o),
    .axi_awlen_o   (axi_awlen_o),
    .axi_awburst_o (axi_awburst_o),
    .axi_awready_i (axi_awready_i),
    .axi_wvalid_o  (axi_wvalid_o),
    .axi_wdata_o   (axi_wdata_o),
    .axi_wstrb_o   (axi_wstrb_o),
    .axi_wlast_o   (axi_wlast_o),
    .axi_wready_i  (axi_wready_i),
    .axi_bvalid_i  (axi_bvalid_i),
    .axi_bresp_i   (axi_bresp_i),
    .axi_bid_i     (axi_bid_i),
    .axi_bready_o  (axi_bready_o),
    .axi_arvalid_o (axi_arvalid_o),
    .axi_araddr_o  (axi_araddr_o),
    .axi_arid_o    (axi_arid_o),
    .axi_arlen_o   (axi_arlen_o),
    .axi_arburst_o (axi_arburst_o),
    .axi_arready_i (axi_arready_i),
    .axi_rvalid_i  (axi_rvalid_i),
    .axi_rdata_i   (axi_rdata_i),
    .axi_rresp_i   (axi_rresp_i),
    .axi_rid_i     (axi_rid_i),
    .axi_rlast_i   (axi_rlast_i),
    .axi_rready_o  (axi_rready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cmd_cyc = 0;
  int done_cnt = 0;
  logic aw_lat_chk = 1'b1;
  logic done_lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- AXI memory responder ----------------
  logic        aw_rdy_en;
  logic [1:0]  slv_bresp;
  logic        slv_rlast_bad;
  logic [31:0] mem [0:255];
  logic [31:0] s_waddr;
  logic [7:0]  s_wcnt;
  logic [31:0] s_raddr;
  logic [7:0]  s_rlen;
  logic [7:0]  s_rcnt;
  logic        s_bvalid;
  logic        s_rvalid;
  logic [7:0]  s_widx;
  logic [7:0]  s_ridx;
  logic [31:0] s_wmask;

  assign axi_awready_i = aw_rdy_en;
  assign axi_wready_i  = 1'b1;
  assign axi_arready_i = 1'b1;
  assign axi_bvalid_i  = s_bvalid;
  assign axi_bresp_i   = slv_bresp;
  assign axi_bid_i     = 4'd0;
  assign axi_rvalid_i  = s_rvalid;
  assign axi_rresp_i   = 2'b00;
  assign axi_rid_i     = 4'd0;
  assign s_widx        = s_waddr[9:2] + s_wcnt;
  assign s_ridx        = s_raddr[9:2] + s_rcnt;
  assign axi_rdata_i   = mem[s_ridx];
  assign axi_rlast_i   = slv_rlast_bad ? (s_rcnt == 8'd1) : (s_rcnt == s_rlen);
  assign s_wmask       = {{8{axi_wstrb_o[3]}}, {8{axi_wstrb_o[2]}},
                          {8{axi_wstrb_o[1]}}, {8{axi_wstrb_o[0]}}};

  always @(posedge clk) begin
    if (rst) begin
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
      s_wcnt   <= 8'd0;
      s_rcnt   <= 8'd0;
      s_waddr  <= 32'd0;
      s_raddr  <= 32'd0;
      s_rlen   <= 8'd0;
    end else begin
      if (axi_awvalid_o && axi_awready_i) begin
        s_waddr <= axi_awaddr_o;
        s_wcnt  <= 8'd0;
      end
      if (axi_wvalid_o && axi_wready_i) begin
        mem[s_widx] <= (mem[s_widx] & ~s_wmask) | (axi_wdata_o & s_wmask);
        s_wcnt      <= s_wcnt + 8'd1;
        if (axi_wlast_o) s_bvalid <= 1'b1;
      end
      if (s_bvalid && axi_bready_o) s_bvalid <= 1'b0;
      if (axi_arvalid_o && axi_arready_i) begin
        s_raddr  <= axi_araddr_o;
        s_rlen   <= axi_arlen_o;
        s_rcnt   <= 8'd0;
        s_rvalid <= 1'b1;
      end else if (s_rvalid && axi_rready_o) begin
        if (s_rcnt == s_rlen) s_rvalid <= 1'b0;
        else s_rcnt <= s_rcnt + 8'd1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  addr_t aw_q[$];
  addr_t ar_q[$];
  beat_t w_q[$];
  beat_t rd_q[$];
  logic  done_q[$];

  always @(negedge clk) begin
    addr_t a;
    beat_t b;
    logic  e;
    if (!rst) begin
      if (axi_awvalid_o && axi_awready_i) begin
        chk("aw_expected", 32'(aw_q.size() != 0), 32'd1);
        if (aw_q.size() != 0) begin
          a = aw_q.pop_front();
          chk("aw_addr", axi_awaddr_o, a.addr);
          chk("aw_len", 32'(axi_awlen_o), 32'(a.len));
          chk("aw_burst_id", {26'd0, axi_awburst_o, axi_awid_o}, {26'd0, 2'b01, 4'd0});
          if (aw_lat_chk) chk("aw_latency", 32'(cyc - cmd_cyc), 32'd1);
        end
      end
      if (axi_arvalid_o && axi_arready_i) begin
        chk("ar_expected", 32'(ar_q.size() != 0), 32'd1);
        if (ar_q.size() != 0) begin
          a = ar_q.pop_front();
          chk("ar_addr", axi_araddr_o, a.addr);
          chk("ar_len", 32'(axi_arlen_o), 32'(a.len));
          chk("ar_burst_id", {26'd0, axi_arburst_o, axi_arid_o}, {26'd0, 2'b01, 4'd0});
          chk("ar_latency", 32'(cyc - cmd_cyc), 32'd1);
        end
      end
      if (axi_wvalid_o && axi_wready_i) begin
        chk("w_expected", 32'(w_q.size() != 0), 32'd1);
        if (w_q.size() != 0) begin
          b = w_q.pop_front();
          chk("w_data", axi_wdata_o, b.data);
          chk("w_strb", 32'(axi_wstrb_o), 32'(b.strb));
          chk("w_last", 32'(axi_wlast_o), 32'(b.last));
        end
      end
      if (axi_rvalid_i) chk("rready_follow", 32'(axi_rready_o), 32'(rd_ready_i));
      if (rd_valid_o && rd_ready_i) begin
        chk("rd_expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) begin
          b = rd_q.pop_front();
          chk("rd_data", rd_data_o, b.data);
          chk("rd_last", 32'(rd_last_o), 32'(b.last));
        end
      end
      if (done_o) begin
        chk("done_expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          e = done_q.pop_front();
          chk("done_error", 32'(error_o), 32'(e));
        end
        chk("done_cmd_ready", 32'(cmd_ready_o), 32'd1);
`ifndef AXI_INIT_TIMEOUT_EN
        chk("timeout_tied_low", 32'(timeout_o), 32'd0);
`endif
        if (done_lat_chk) chk("done_latency", 32'(cyc - cmd_cyc), 32'd4);
        done_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic rd_toggle = 1'b0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rd_ready_i = 1'b1;
    forever begin
      tick();
      if (rd_toggle) rd_ready_i = ~rd_ready_i;
      else rd_ready_i = 1'b1;
    end
  end

  task automatic exp_write(input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] base, input logic err);
    aw_q.push_back('{addr: addr, len: len});
    for (int i = 0; i <= int'(len); i++)
      w_q.push_back('{data: base + 32'(i), strb: 4'hF, last: (i == int'(len))});
    done_q.push_back(err);
  endtask

  task automatic exp_read(input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] base, input logic err);
    ar_q.push_back('{addr: addr, len: len});
    for (int i = 0; i <= int'(len); i++)
      rd_q.push_back('{data: base + 32'(i), strb: 4'hF, last: (i == int'(len))});
    done_q.push_back(err);
  endtask

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    int g = 0;
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_len_i   = len;
    while (!cmd_ready_o && g < 200) begin
      tick();
      g++;
    end
    if (g >= 200) chk("cmd_accept_bound", 32'(cmd_ready_o), 32'd1);
    cmd_cyc = cyc;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic feed(input int n, input logic [31:0] base);
    int b = 0;
    int g = 0;
    while (b < n && g < 200) begin
      wr_valid_i = 1'b1;
      wr_data_i  = base + 32'(b);
      wr_strb_i  = 4'hF;
      if (wr_ready_o) b++;
      tick();
      g++;
    end
    wr_valid_i = 1'b0;
    if (g >= 200) chk("wdata_feed_bound", 32'(b), 32'(n));
  endtask

  task automatic wait_done(input int target);
    int g = 0;
    while (done_cnt < target && g < 500) begin
      tick();
      g++;
    end
    chk("done_seen", 32'(done_cnt >= target), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst           = 1'b1;
    cmd_valid_i   = 1'b0;
    cmd_write_i   = 1'b0;
    cmd_addr_i    = 32'd0;
    cmd_len_i     = 8'd0;
    wr_valid_i    = 1'b1;
    wr_data_i     = 32'd0;
    wr_strb_i     = 4'h0;
    aw_rdy_en     = 1'b1;
    slv_bresp     = 2'b00;
    slv_rlast_bad = 1'b0;
    repeat (3) tick();

    // Reset state, with wr_valid_i and wready high so a non-idle state would show through.
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_valids", {26'd0, axi_awvalid_o, axi_arvalid_o, axi_wvalid_o, axi_bready_o,
                       axi_rready_o, axi_wlast_o}, 32'd0);
    chk("rst_addr", axi_awaddr_o | axi_araddr_o, 32'd0);
    chk("rst_len_id", {16'd0, axi_awlen_o | axi_arlen_o, axi_awid_o, axi_arid_o}, 32'd0);
    chk("rst_burst", {28'd0, axi_awburst_o, axi_arburst_o}, 32'h5);
    chk("rst_status", {28'd0, done_o, error_o, timeout_o, rd_last_o}, 32'd0);
    chk("rst_streams", {30'd0, wr_ready_o, rd_valid_o}, 32'd0);
    rst        = 1'b0;
    wr_valid_i = 1'b0;
    tick();

    // 4-beat write, zero-wait slave.
    exp_write(32'h100, 8'd3, 32'hA0, 1'b0);
    do_cmd(1'b1, 32'h100, 8'd3);
    feed(4, 32'hA0);
    wait_done(1);

    // Readback with rd_ready toggling every cycle.
    rd_toggle = 1'b1;
    exp_read(32'h100, 8'd3, 32'hA0, 1'b0);
    do_cmd(1'b0, 32'h100, 8'd3);
    wait_done(2);
    rd_toggle = 1'b0;

    // Single-beat write with SLVERR response; also checks the N+4 done latency.
    slv_bresp    = 2'b10;
    done_lat_chk = 1'b1;
    exp_write(32'h200, 8'd0, 32'h55, 1'b1);
    do_cmd(1'b1, 32'h200, 8'd0);
    feed(1, 32'h55);
    wait_done(3);
    done_lat_chk = 1'b0;
    slv_bresp    = 2'b00;

    // Back-to-back write after the error: status must be clean again. Low addr bits ignored.
    exp_write(32'h204, 8'd1, 32'h10, 1'b0);
    do_cmd(1'b1, 32'h207, 8'd1);
    feed(2, 32'h10);
    wait_done(4);

    // Early rlast on beat 2: error reported, all four beats still delivered.
    slv_rlast_bad = 1'b1;
    exp_read(32'h100, 8'd3, 32'hA0, 1'b1);
    do_cmd(1'b0, 32'h100, 8'd3);
    wait_done(5);
    slv_rlast_bad = 1'b0;

    // Reset during the second W beat.
    aw_q.push_back('{addr: 32'h300, len: 8'd3});
    w_q.push_back('{data: 32'hC0, strb: 4'hF, last: 1'b0});
    do_cmd(1'b1, 32'h300, 8'd3);
    wr_valid_i = 1'b1;
    wr_strb_i  = 4'hF;
    wr_data_i  = 32'hC0;
    for (int g = 0; g < 20 && !wr_ready_o; g++) tick();
    tick();
    wr_data_i = 32'hC1;
    chk("rst_mid_w_presented", 32'(axi_wvalid_o), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_wvalid", 32'(axi_wvalid_o), 32'd0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready_o), 32'd1);
    rst        = 1'b0;
    wr_valid_i = 1'b0;
    tick();

    // Post-reset read of the earlier 2-beat write.
    exp_read(32'h204, 8'd1, 32'h10, 1'b0);
    do_cmd(1'b0, 32'h204, 8'd1);
    wait_done(6);

`ifdef AXI_INIT_TIMEOUT_EN
    // Stall AW long enough for the watchdog; the transaction still completes afterwards.
    aw_lat_chk = 1'b0;
    aw_rdy_en  = 1'b0;
    exp_write(32'h300, 8'd0, 32'h77, 1'b0);
    do_cmd(1'b1, 32'h300, 8'd0);
    for (int i = 0; i < 70000; i++) begin
      if (i == 60000) chk("timeout_not_early", 32'(timeout_o), 32'd0);
      if (timeout_o) break;
      tick();
    end
    chk("timeout_set", 32'(timeout_o), 32'd1);
    aw_rdy_en = 1'b1;
    feed(1, 32'h77);
    wait_done(7);
    tick();
    chk("timeout_sticky", 32'(timeout_o), 32'd1);
`endif

    repeat (3) tick();
    chk("aw_queue_drained", 32'(aw_q.size()), 32'd0);
    chk("ar_queue_drained", 32'(ar_q.size()), 32'd0);
    chk("w_queue_drained", 32'(w_q.size()), 32'd0);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_pmem_initiator.md
# axi_pmem_initiator

AXI4 initiator that converts a simple command/data-stream request into single-outstanding INCR bursts on a 32-bit AXI port. It is the master-side counterpart to the TCM's AXI slave port and is used by loaders and debug/DMA agents to read and write TCM, or any AXI responder in the SoC. It handles one transaction at a time, counts beats, generates `wlast`, checks `rlast`/IDs, and reports completion status.

## Interface
- `AXI_ID`, 4'd0: constant ID driven on `axi_awid_o`/`axi_arid_o`; expected on `bid`/`rid`.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid_i` in 1 / `cmd_ready_o` out 1: command handshake.
- `cmd_write_i` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr_i` in 32: byte address, word aligned ([1:0] ignored, driven 0).
- `cmd_len_i` in 8: beats minus one (AXI LEN encoding).
- `wr_valid_i` in 1 / `wr_ready_o` out 1 / `wr_data_i` in 32 / `wr_strb_i` in 4: write data stream.
- `rd_valid_o` out 1 / `rd_ready_i` in 1 / `rd_data_o` out 32 / `rd_last_o` out 1: read data stream.
- `done_o` out 1: one-cycle completion pulse. `error_o` out 1: status, valid with `done_o`.
- `timeout_o` out 1: sticky watchdog flag (only with `AXI_INIT_TIMEOUT_EN`).
- AXI AW: `axi_awvalid_o`, `axi_awaddr_o[31:0]`, `axi_awid_o[3:0]`, `axi_awlen_o[7:0]`, `axi_awburst_o[1:0]`, `axi_awready_i`.
- AXI W: `axi_wvalid_o`, `axi_wdata_o[31:0]`, `axi_wstrb_o[3:0]`, `axi_wlast_o`, `axi_wready_i`.
- AXI B: `axi_bvalid_i`, `axi_bresp_i[1:0]`, `axi_bid_i[3:0]`, `axi_bready_o`.
- AXI AR: `axi_arvalid_o`, `axi_araddr_o[31:0]`, `axi_arid_o[3:0]`, `axi_arlen_o[7:0]`, `axi_arburst_o[1:0]`, `axi_arready_i`.
- AXI R: `axi_rvalid_i`, `axi_rdata_i[31:0]`, `axi_rresp_i[1:0]`, `axi_rid_i[3:0]`, `axi_rlast_i`, `axi_rready_o`.

## Operation
- FSM states: IDLE, AW, W, B, AR, R.
- IDLE: `cmd_ready_o`=1. On `cmd_valid_i` latch addr/len/write, clear beat counter and error accumulator; go to AW (write) or AR (read).
- AW/AR: registered `*valid_o`=1 with latched addr/len, burst=2'b01 (INCR), id=`AXI_ID`; hold until `*ready_i`, then go to W or R.
- W: `axi_wvalid_o = wr_valid_i`, `wr_ready_o = axi_wready_i`, data/strb pass through. `axi_wlast_o` = (beat==len). Beat increments per W handshake; last handshake -> B.
- B: `axi_bready_o`=1; on `bvalid` accumulate error (`bresp`!=0 or `bid`!=`AXI_ID`) -> IDLE, pulse `done_o`.
- R: `rd_valid_o = axi_rvalid_i`, `axi_rready_o = rd_ready_i`, data passes through, `rd_last_o` = (beat==len). Error if `rresp`!=0, `rid`!=`AXI_ID`, or `axi_rlast_i` != (beat==len). Final handshake -> IDLE, pulse `done_o`.
- Error accumulation is a sticky OR over the whole transaction; it never aborts the burst.
- Caller keeps bursts within a 4 KB boundary; the block does not split bursts.

## Timing
- Reset values: `cmd_ready_o` 1; all AXI valid/ready/last outputs 0; addr/len/id 0; burst 2'b01; `done_o`, `error_o`, `timeout_o` 0; `wr_ready_o`, `rd_valid_o` 0.
- Command accepted at cycle N -> `axi_awvalid_o`/`axi_arvalid_o` high at N+1.
- Zero-wait slave, write of LEN=0: cmd N, AW N+1, W N+2, B N+3, `done_o` N+4.
- `done_o` is registered: it is high the cycle after the B or final R handshake, and `cmd_ready_o` is 1 in that same cycle. Back-to-back commands are allowed.
- AW is never issued concurrently with W. W data presented before state W is not consumed.
- Synchronous `rst` mid-burst returns to IDLE immediately and drops all valids. The system must reset the slave together with this block.

## Configuration
- `AXI_INIT_TIMEOUT_EN` defined: a 16-bit counter counts consecutive cycles in any non-IDLE state without an AXI handshake. At 0xFFFF it sets `timeout_o` (sticky until `rst`). The transaction continues; it is not aborted.
- Not defined: no counter; `timeout_o` is tied to 0.

## Structure
- Shared package `axi_pkg`: AXI burst/resp constants (`AXI_BURST_INCR`=2'b01, `AXI_RESP_OKAY`=2'b00) and the FSM state enum encoding.
- Single module. An optional sub-module `axi_init_watchdog` holds the timeout counter, instantiated only under the macro.

## Test plan
- Write, addr 0x0000_0100, len 3, data 0xA0..A3, strb 4'hF, zero-wait TCM -> one AW with LEN=3, `wlast` on the 4th beat only, `done_o` with `error_o`=0; readback matches.
- Read, addr 0x100, len 3, `rd_ready_i` toggling every other cycle -> `axi_rready_o` follows, data 0xA0..A3 in order, `rd_last_o` on beat 4, `done_o`=1 / `error_o`=0.
- Slave returns `bresp`=2'b10 -> `done_o` with `error_o`=1; next command has `error_o`=0.
- Slave asserts `rlast` on beat 2 of a len=3 read -> `error_o`=1 at done, all 4 beats still consumed.
- `rst` asserted during W beat 2 -> next cycle `axi_wvalid_o`=0, `cmd_ready_o`=1.
- With `AXI_INIT_TIMEOUT_EN`, `awready` held 0 for 65536 cycles -> `timeout_o` goes 1 and stays 1 after `awready` is released and the transaction completes.
